// File: rtl/adc_trig_capture.sv
// Decimating ADC capture into a circular buffer with level-crossing trigger and a fixed
// pre-trigger history; the finished record is read back oldest-first, one sample per request.
module adc_trig_capture #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 256,
    parameter int DECIM_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adc_clk,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               arm,
    input  logic               force_trig,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_fall,
    input  logic [DECIM_W-1:0] decim,
    input  logic               rd_req,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic               trig_seen
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE_DEPTH);
    localparam logic [ADDR_W:0]   POST_SMP = (ADDR_W+1)'(DEPTH - PRE_DEPTH - 1);
    localparam logic [ADDR_W:0]   POST_FRC = (ADDR_W+1)'(DEPTH - PRE_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]         sync_q;
    logic               s_stb;
    logic               vld_p1_q;
    logic [DATA_W-1:0]  smp_p1_q;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d, fill_cnt_q, fill_cnt_d;
    logic [ADDR_W:0]    post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0]  prev_q;
    logic               trig_seen_q, trig_seen_d;
    logic               rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               keep, we, trig, rd_en;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    function automatic logic crossed(input logic [DATA_W-1:0] prv, input logic [DATA_W-1:0] cur,
                                     input logic [DATA_W-1:0] lvl, input logic fall);
        logic hit;
        if (fall) hit = (prv > lvl) && (cur <= lvl);
        else      hit = (prv < lvl) && (cur >= lvl);
        return hit;
    endfunction

    // Stage p0: adc_clk is sampled as data; its synchronised rising edge strobes the sample in
    assign s_stb = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], adc_clk};
            vld_p1_q <= s_stb;
        end
    end

    always_ff @(posedge clk) begin
        if (s_stb) smp_p1_q <= adc_data;
    end

    // Stage p1: decimate, write and evaluate the trigger
    assign keep = vld_p1_q && (dcnt_q == '0) && busy;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_FILL:  if (fill_cnt_q == PRE_A) state_d = S_WAIT;
                S_WAIT:  if (trig) state_d = S_POST;
                S_POST:  if (post_cnt_q == '0) state_d = S_DONE;
                S_IDLE, S_DONE: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
        done  = (state_q == S_DONE);
        we    = 1'b0;
        trig  = 1'b0;
        rd_en = 1'b0;
        if (!arm) begin
            case (state_q)
                S_FILL: we = keep && (fill_cnt_q != PRE_A);
                S_WAIT: begin
                    we   = keep;
                    trig = force_trig || (keep && crossed(prev_q, smp_p1_q, trig_level, trig_fall));
                end
                S_POST: we = keep && (post_cnt_q != '0);
                S_DONE: rd_en = rd_req;
                default: ;
            endcase
        end
    end

    // A forced trigger with no sample in hand makes the next kept sample the trigger point
    always_comb begin
        dcnt_d      = dcnt_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_ptr_d  = trig_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_seen_d = trig_seen_q;
        if (arm) begin
            dcnt_d      = '0;
            wr_ptr_d    = '0;
            fill_cnt_d  = '0;
            post_cnt_d  = '0;
            trig_ptr_d  = '0;
            rd_ptr_d    = '0;
            trig_seen_d = 1'b0;
        end else begin
            if (vld_p1_q && busy) dcnt_d = (dcnt_q == '0) ? decim : dcnt_q - 1'b1;
            if (we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (we && state_q == S_FILL) fill_cnt_d = fill_cnt_q + 1'b1;
            if (trig) begin
                trig_ptr_d  = wr_ptr_q;
                post_cnt_d  = keep ? POST_SMP : POST_FRC;
                trig_seen_d = 1'b1;
            end else if (we && state_q == S_POST) begin
                post_cnt_d = post_cnt_q - 1'b1;
            end
            if (state_q == S_POST && post_cnt_q == '0) rd_ptr_d = trig_ptr_q - PRE_A;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q      <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            trig_seen_q <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_ptr_q  <= trig_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_seen_q <= trig_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr_q] <= smp_p1_q;
            prev_q          <= smp_p1_q;
        end
    end

    // Stage p2: synchronous read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign trig_seen = trig_seen_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture: scenario table of captures checked against a kept-sample model,
// plus hand sequences for reset mid-capture and re-arm racing a trigger.
module tb_adc_trig_capture;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int PRE    = 256;
    localparam int DECIM_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset, adc_clk, arm, force_trig, trig_fall, rd_req;
    logic [DATA_W-1:0]  adc_data, trig_level, rd_data;
    logic [DECIM_W-1:0] decim;
    logic rd_valid, busy, done, trig_seen;

    adc_trig_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE), .DECIM_W(DECIM_W)) dut (
        .clk(clk), .reset(reset), .adc_clk(adc_clk), .adc_data(adc_data), .arm(arm),
        .force_trig(force_trig), .trig_level(trig_level), .trig_fall(trig_fall), .decim(decim),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .trig_seen(trig_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;        // 0 ramp up, 1 ramp down, 2 constant 10, 3 random
        int d;
        int lvl;
        bit fall;
        int force_at;   // samples driven before force_trig, -1 = none
        int exp_n;      // hand-derived samples until done, -1 = model only
        int exp_first;
        int exp_trig;
    } scen_t;

    scen_t tbl[5];
    int    smp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int pat, input int idx);
        case (pat)
            0:       return 8'(idx % 256);
            1:       return 8'(255 - idx % 256);
            2:       return 8'd10;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic bit crossing(input int p, input int c, input int lvl, input bit fall);
        if (fall) return (p > lvl) && (c <= lvl);
        return (p < lvl) && (c >= lvl);
    endfunction

    // One ADC sample: 2 clk high, 3 clk low; optionally arm on the cycle the sample is acted on
    task automatic drive_sample(input logic [7:0] v, input bit arm_mid);
        adc_data = v;
        adc_clk  = 1'b1;
        smp_q.push_back(int'(v));
        repeat (2) @(negedge clk);
        adc_clk = 1'b0;
        @(negedge clk);
        if (arm_mid) arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_capture(input int pat, input int start, input int force_at,
                               input int max_n, output int n);
        n = 0;
        while (done !== 1'b1 && n < max_n) begin
            if (n == force_at) begin
                force_trig = 1'b1;
                @(negedge clk);
                force_trig = 1'b0;
            end
            drive_sample(gen(pat, start + n), 1'b0);
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL capture_timeout: done=%0b after %0d samples, required 1", done, n);
        end
    endtask

    task automatic check_capture(input scen_t sc, input int n, input string tag);
        int kept[$];
        int t, k_tot, exp_n, base, e, bad, bad_idx, bad_got, bad_exp, bad_vld;
        for (int i = 0; i < smp_q.size(); i += sc.d + 1) kept.push_back(smp_q[i]);
        t = -1;
        if (sc.force_at >= 0) t = (sc.force_at + sc.d) / (sc.d + 1);
        else
            for (int i = PRE; i < kept.size(); i++)
                if (t < 0 && crossing(kept[i-1], kept[i], sc.lvl, sc.fall)) t = i;
        if (t < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_model: no trigger in %0d kept samples, required one", tag, kept.size());
            return;
        end
        k_tot = t + DEPTH - PRE;
        exp_n = (k_tot - 1) * (sc.d + 1) + 1;
        chk({tag, "_samples"}, n, exp_n);
        if (sc.exp_n >= 0) chk({tag, "_samples_hand"}, n, sc.exp_n);
        chk({tag, "_trig_seen"}, int'(trig_seen), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        if (kept.size() < k_tot) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_kept: got %0d kept samples, required %0d", tag, kept.size(), k_tot);
            return;
        end
        base = t - PRE;
        bad = 0; bad_idx = 0; bad_got = 0; bad_exp = 0; bad_vld = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            e = kept[base + k % DEPTH];
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            if (rd_valid !== 1'b1 || int'(rd_data) != e) begin
                if (bad == 0) begin
                    bad_idx = k; bad_got = int'(rd_data); bad_exp = e; bad_vld = int'(rd_valid);
                end
                bad++;
            end
            if (k == 0 && sc.exp_first >= 0) chk({tag, "_read_first"}, int'(rd_data), sc.exp_first);
            if (k == PRE && sc.exp_trig >= 0) chk({tag, "_read_trig"}, int'(rd_data), sc.exp_trig);
            if (k == DEPTH) chk({tag, "_read_wrap"}, int'(rd_data), kept[base]);
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_readout: %0d bad reads, first at %0d got %0d (valid %0d), expected %0d",
                     tag, bad, bad_idx, bad_got, bad_vld, bad_exp);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: cycle budget exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        scen_t sc;
        tbl[0] = '{0, 0, 100, 1'b0, -1, 1124, 100, 100};
        tbl[1] = '{0, 3, 100, 1'b0, -1, 4193, 100, 100};
        tbl[2] = '{1, 0, 50, 1'b1, -1, 1229, 50, 50};
        tbl[3] = '{2, 0, 200, 1'b0, 260, 1028, 10, 10};
        tbl[4] = '{3, int'($urandom_range(0, 1)), int'($urandom_range(20, 235)),
                   ($urandom_range(0, 1) == 1), -1, -1, -1, -1};

        reset = 1'b1; adc_clk = 1'b0; adc_data = '0; arm = 1'b0; force_trig = 1'b0;
        trig_level = '0; trig_fall = 1'b0; decim = '0; rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_trig_seen", int'(trig_seen), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 5; s++) begin
            sc = tbl[s];
            decim      = 8'(sc.d);
            trig_level = 8'(sc.lvl);
            trig_fall  = sc.fall;
            arm_pulse();
            smp_q.delete();
            run_capture(sc.pat, 0, sc.force_at, 6000, n);
            check_capture(sc, n, $sformatf("scen%0d", s));
        end

        // Reset in the middle of the post-trigger phase
        decim = '0; trig_level = 8'd100; trig_fall = 1'b0;
        arm_pulse();
        smp_q.delete();
        for (int i = 0; i < 400; i++) drive_sample(gen(0, i), 1'b0);
        chk("post_busy", int'(busy), 1);
        chk("post_trig_seen", int'(trig_seen), 1);
        chk("post_done", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_post_busy", int'(busy), 0);
        chk("rst_post_done", int'(done), 0);
        chk("rst_post_trig_seen", int'(trig_seen), 0);
        chk("rst_post_rd_valid", int'(rd_valid), 0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        chk("idle_rd_valid", int'(rd_valid), 0);
        @(negedge clk);

        // Re-arm in the very cycle a crossing would trigger
        arm_pulse();
        smp_q.delete();
        for (int i = 0; i < 356; i++) drive_sample(gen(0, i), 1'b0);
        drive_sample(gen(0, 356), 1'b1);
        chk("rearm_trig_seen", int'(trig_seen), 0);
        chk("rearm_busy", int'(busy), 1);
        chk("rearm_done", int'(done), 0);
        smp_q.delete();
        run_capture(0, 357, -1, 6000, n);
        sc = '{0, 0, 100, 1'b0, -1, 1279, 100, 100};
        check_capture(sc, n, "rearm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
